fetch_seq_ctrl: RTL and testbench
=================================

// Module: fetch_seq_ctrl
// PURPOSE
//   Multi-step instruction sequencer for the LEGv8 datapath: owns the PC, fetches a
//   32-bit word from instruction memory over a req/ack handshake, and holds it on instr
//   for the instruction-field decoder. Pulses the execute stage and waits for its
//   completion, then advances the PC by +4 or to a taken branch target.
//   Halts on an all-zero instruction word.
// PARAMETERS
//   RESET_PC       64'h0  PC value after reset and after a restart
//   FETCH_TIMEOUT  16     max cycles imem_req may stay high without imem_ack (>=2)
// PORTS
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   begin/restart execution (level sampled each cycle)
//   imem_req    out  1   fetch request, held until ack
//   imem_addr   out  64  fetch address (= pc)
//   imem_ack    in   1   fetch data valid this cycle
//   imem_rdata  in   32  fetched instruction word
//   instr       out  32  latched instruction to decoder
//   ex_start    out  1   one-cycle execute pulse
//   ex_done     in   1   execute stage finished
//   br_taken    in   1   branch taken (valid with ex_done)
//   br_offset   in   64  sign-extended word offset (valid with ex_done)
//   pc          out  64  current PC
//   busy        out  1   high in FETCH/DECODE/EXEC
//   halted      out  1   sticky: zero instruction seen
//   fetch_err   out  1   sticky: fetch timeout
//   cyc_cnt     out  32  busy-cycle counter (PERF_CNT_EN)
//   ret_cnt     out  32  retired-instruction counter (PERF_CNT_EN)
// BEHAVIOUR
//   - Reset (async, immediate): state IDLE, pc=RESET_PC, instr=0, all 1-bit outputs 0,
//     counters 0; imem_req drops in the same instant.
//   - FSM: IDLE, FETCH, DECODE, EXEC, HALT, ERROR.
//   - IDLE: start=1 -> FETCH. In FETCH, imem_req=1 and imem_addr=pc.
//   - FETCH: ack in the first FETCH cycle is legal (min 1 cycle). On ack:
//     instr<=imem_rdata -> DECODE. Timeout counter resets on FETCH entry.
//     At FETCH_TIMEOUT cycles with no ack: fetch_err<=1, req drops -> ERROR.
//   - DECODE (exactly 1 cycle): if instr==32'h0 -> halted<=1 -> HALT, no ex_start.
//     Otherwise ex_start=1 for this cycle only -> EXEC.
//   - EXEC: wait for ex_done. On ex_done: pc<=br_taken ? pc+(br_offset<<2) : pc+4,
//     computed modulo 2^64 (wraps, no error) -> FETCH.
//   - Best case per instruction: FETCH 1 + DECODE 1 + EXEC 1 = 3 cycles.
//   - imem_ack outside FETCH is ignored. ex_done outside EXEC is ignored.
//     br_taken and br_offset are sampled only with ex_done.
//   - start while busy: ignored. start in HALT or ERROR: pc<=RESET_PC, halted and
//     fetch_err cleared, counters cleared -> FETCH.
//   - HALT and ERROR hold pc and instr; imem_req=0, ex_start=0.
// CONFIGURATION
//   PERF_CNT_EN defined:
//     - cyc_cnt +1 every cycle busy=1.
//     - ret_cnt +1 on each accepted ex_done.
//     - Both saturate at 32'hFFFFFFFF and clear on reset and on start from IDLE/HALT/ERROR.
//   PERF_CNT_EN undefined: no counter logic; cyc_cnt and ret_cnt tied to 0.
//   Ports exist in both builds.
// TESTING
//   1. Reset, start=1, ack next cycle with rdata=32'h8B020020, ex_done after 2 cycles,
//      br_taken=0 -> instr=32'h8B020020, exactly one ex_start, pc 0->4, imem_addr=4.
//   2. EXEC at pc=0x40, ex_done with br_taken=1, br_offset=64'hFFFFFFFFFFFFFFFC
//      -> pc=0x30.
//   3. Fetch returns 32'h0 -> halted=1, busy=0, no ex_start.
//      Then start=1 -> pc=RESET_PC, halted=0, FETCH.
//   4. Withhold imem_ack for 16 cycles -> fetch_err=1, imem_req=0, state ERROR.
//      An ack arriving later has no effect.
//   5. Assert rst_n=0 mid-EXEC with pc=0x100 -> pc=0 and outputs 0 immediately.
//      A subsequent ex_done is ignored.
//   6. PERF_CNT_EN: run 3 instructions with 1-cycle ack and ex_done -> ret_cnt=3,
//      cyc_cnt=9. Without the macro both read 0.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// LEGv8 fetch/decode/execute sequencer: owns the PC, fetches over req/ack, pulses execute.
// Optional performance counters are built when the PERF_CNT_EN macro is defined.
module fetch_seq_ctrl #(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        ex_start,
    input  logic        ex_done,
    input  logic        br_taken,
    input  logic [63:0] br_offset,
    output logic [63:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        fetch_err,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    state_t        state;
    logic [TW-1:0] to_cnt;

    assign imem_addr = pc;

    // ex_start is decided on the ack edge so the pulse lines up with the DECODE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            imem_req  <= 1'b0;
            ex_start  <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            to_cnt    <= '0;
        end else begin
            ex_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        ex_start <= (imem_rdata != 32'h0);
                        state    <= S_DECODE;
                    end else if (to_cnt == TW'(FETCH_TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_ERROR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (instr == 32'h0) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ex_done) begin
                        pc       <= br_taken ? (pc + (br_offset << 2)) : (pc + 64'd4);
                        imem_req <= 1'b1;
                        to_cnt   <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_HALT, S_ERROR: begin
                    if (start) begin
                        pc        <= RESET_PC;
                        halted    <= 1'b0;
                        fetch_err <= 1'b0;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic restart;
    logic retire;

    assign restart = start && (state == S_IDLE || state == S_HALT || state == S_ERROR);
    assign retire  = (state == S_EXEC) && ex_done;

    // Saturating counters; restart never coincides with a busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else if (restart) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (busy && cyc_cnt != 32'hFFFF_FFFF) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (retire && ret_cnt != 32'hFFFF_FFFF) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`else
    assign cyc_cnt = 32'd0;
    assign ret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl; expected values are hand-computed per scenario.
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        ex_start;
    logic        ex_done;
    logic        br_taken;
    logic [63:0] br_offset;
    logic [63:0] pc;
    logic        busy;
    logic        halted;
    logic        fetch_err;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    int errors = 0;
    int checks = 0;
    int ex_pulses = 0;
    int pulses_before;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_seq_ctrl #(
        .RESET_PC     (64'h0),
        .FETCH_TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .instr     (instr),
        .ex_start  (ex_start),
        .ex_done   (ex_done),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .fetch_err (fetch_err),
        .cyc_cnt   (cyc_cnt),
        .ret_cnt   (ret_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ex_start) ex_pulses++;
    endtask

    // From a FETCH cycle: 1-cycle ack, 1-cycle DECODE, ex_done in first EXEC cycle.
    task automatic run_instr(input logic [31:0] word, input logic taken, input logic [63:0] offset);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        tick();
        ex_done    = 1'b1;
        br_taken   = taken;
        br_offset  = offset;
        tick();
        ex_done    = 1'b0;
        br_taken   = 1'b0;
        br_offset  = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ex_done    = 1'b0;
        br_taken   = 1'b0;
        br_offset  = '0;
        #3;
        check_output("rst_pc", pc, 64'h0);
        check_output("rst_req", {63'd0, imem_req}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_instr", {32'd0, instr}, 64'd0);
        check_output("rst_flags", {62'd0, halted, fetch_err}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single straight-line instruction.
        $display("[TB] basic fetch/execute");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t1_req", {63'd0, imem_req}, 64'd1);
        check_output("t1_busy", {63'd0, busy}, 64'd1);
        check_output("t1_addr0", imem_addr, 64'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h8B02_0020;
        tick();
        imem_ack   = 1'b0;
        check_output("t1_instr", {32'd0, instr}, 64'h8B02_0020);
        check_output("t1_req_drop", {63'd0, imem_req}, 64'd0);
        tick();
        tick();
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        check_output("t1_pulses", 64'(ex_pulses), 64'd1);
        check_output("t1_pc", pc, 64'h4);
        check_output("t1_addr", imem_addr, 64'h4);
        check_output("t1_refetch", {63'd0, imem_req}, 64'd1);

        // Branches, including a backward one.
        $display("[TB] branches");
        start = 1'b1;
        run_instr(32'hB400_0001, 1'b1, 64'd15);
        start = 1'b0;
        check_output("t2_fwd", pc, 64'h40);
        run_instr(32'hB400_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        check_output("t2_back", pc, 64'h30);
        check_output("t2_pulses", 64'(ex_pulses), 64'd3);

        // Zero word halts without an execute pulse.
        $display("[TB] halt");
        pulses_before = ex_pulses;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0;
        tick();
        imem_ack = 1'b0;
        tick();
        check_output("t3_halted", {63'd0, halted}, 64'd1);
        check_output("t3_busy", {63'd0, busy}, 64'd0);
        check_output("t3_no_exstart", 64'(ex_pulses - pulses_before), 64'd0);
        check_output("t3_pc_hold", pc, 64'h30);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check_output("t3_ack_ignored", {32'd0, instr}, 64'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t3_restart_pc", pc, 64'h0);
        check_output("t3_restart_halt", {63'd0, halted}, 64'd0);
        check_output("t3_restart_req", {63'd0, imem_req}, 64'd1);

        // Fetch timeout.
        $display("[TB] fetch timeout");
        for (int i = 0; i < 15; i++) tick();
        check_output("t4_still_waiting", {62'd0, imem_req, fetch_err}, 64'b10);
        tick();
        check_output("t4_err", {63'd0, fetch_err}, 64'd1);
        check_output("t4_req", {63'd0, imem_req}, 64'd0);
        check_output("t4_busy", {63'd0, busy}, 64'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        ex_done    = 1'b1;
        tick();
        imem_ack = 1'b0;
        ex_done  = 1'b0;
        check_output("t4_late_ack", {32'd0, instr}, 64'h0);
        check_output("t4_err_sticky", {63'd0, fetch_err}, 64'd1);
        check_output("t4_pc_hold", pc, 64'h0);

        // Counters over three back-to-back instructions.
        $display("[TB] counters");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("t6_err_clr", {63'd0, fetch_err}, 64'd0);
        run_instr(32'h8B02_0020, 1'b0, 64'd0);
        run_instr(32'h8B02_0021, 1'b0, 64'd0);
        run_instr(32'h8B02_0022, 1'b0, 64'd0);
        check_output("t6_pc", pc, 64'hC);
        check_output("t6_cyc", {32'd0, cyc_cnt}, PERF ? 64'd9 : 64'd0);
        check_output("t6_ret", {32'd0, ret_cnt}, PERF ? 64'd3 : 64'd0);

        // Asynchronous reset in the middle of EXEC.
        $display("[TB] async reset");
        run_instr(32'h8B02_0023, 1'b1, 64'd61);
        check_output("t5_pc_setup", pc, 64'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'h8B02_0024;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_output("t5_pc", pc, 64'h0);
        check_output("t5_outs", {59'd0, imem_req, ex_start, busy, halted, fetch_err}, 64'd0);
        check_output("t5_instr", {32'd0, instr}, 64'h0);
        check_output("t5_cnts", {cyc_cnt, ret_cnt}, 64'd0);
        tick();
        rst_n     = 1'b1;
        ex_done   = 1'b1;
        br_taken  = 1'b1;
        br_offset = 64'd8;
        tick();
        ex_done  = 1'b0;
        br_taken = 1'b0;
        check_output("t5_done_ignored", pc, 64'h0);
        check_output("t5_idle", {62'd0, busy, imem_req}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
